// File: rtl/busio_pkg.sv
// Shared types for the external memory responder.
// State encoding, wait-count and strobe widths.
package busio_pkg;

  localparam int WAIT_W = 4;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/ext_mem_responder_if.sv
// Initiator-side transfer bus of the external memory responder.
// Master drives requests; slave returns ready and data.
interface ext_mem_responder_if;
  import busio_pkg::*;

  logic              ext_valid;
  logic              ext_instruction;
  logic [31:0]       ext_address;
  logic [31:0]       ext_write_data;
  logic [STRB_W-1:0] ext_write_strobe;
  logic              ext_ready;
  logic [31:0]       ext_read_data;

  modport master (
    output ext_valid,
    output ext_instruction,
    output ext_address,
    output ext_write_data,
    output ext_write_strobe,
    input  ext_ready,
    input  ext_read_data
  );

  modport slave (
    input  ext_valid,
    input  ext_instruction,
    input  ext_address,
    input  ext_write_data,
    input  ext_write_strobe,
    output ext_ready,
    output ext_read_data
  );

endinterface

// File: rtl/bus_word_ram.sv
// Word storage with per-byte-lane write enables.
// Synchronous read and write; contents are never reset.
module bus_word_ram
  import busio_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [STRB_W-1:0]        we,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// External memory responder: captures one request, waits,
// then answers with a single-cycle ready pulse.
module ext_mem_responder
  import busio_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ext_mem_responder_if.slave  bus,
  output logic                busy,
  output logic [7:0]          err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WC = WAIT_W'(WAIT_CYCLES);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [29:0]       addr;
  logic [31:0]       wdata;
  logic [STRB_W-1:0] strb;
  logic              instr;
  logic              ready_q;
  logic              rd_ok;

  logic              in_range;
  logic              is_wr;
  logic              fault;
  logic              resp;
  logic [STRB_W-1:0] we;
  logic [31:0]       ram_q;

  // Fetches never write, even with a strobe set
  assign in_range = (addr[29:AW] == '0);
  assign is_wr    = |strb && !instr;
  assign fault    = !in_range || (instr && |strb);
  assign resp     = (state == S_RESP) && rst_n;
  assign we       = (resp && in_range && is_wr) ? strb : '0;

  bus_word_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .rd_en (resp),
    .addr  (addr[AW-1:0]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  assign bus.ext_ready     = ready_q;
  assign bus.ext_read_data = rd_ok ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      strb      <= '0;
      instr     <= 1'b0;
      ready_q   <= 1'b0;
      rd_ok     <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (bus.ext_valid) begin
            addr  <= bus.ext_address[31:2];
            wdata <= bus.ext_write_data;
            strb  <= bus.ext_write_strobe;
            instr <= bus.ext_instruction;
            cnt   <= WC;
            busy  <= 1'b1;
            state <= (WC != '0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= 1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          rd_ok   <= in_range && !is_wr;
          busy    <= 1'b0;
          state   <= S_IDLE;
          if (fault && err_count != 8'hFF) begin
            err_count <= err_count + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized bench for ext_mem_responder against a
// word-array reference model.
module tb_ext_mem_responder;
  import busio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, busy0;
  logic [7:0] err_count, err_count0;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] model_mem [1024];
  int          model_err = 0;

  ext_mem_responder_if bus ();
  ext_mem_responder_if bus0 ();

  ext_mem_responder #(
    .DEPTH       (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .err_count (err_count)
  );

  ext_mem_responder #(
    .DEPTH       (64),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0.slave),
    .busy      (busy0),
    .err_count (err_count0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer on the WAIT_CYCLES=2 instance, checked
  // against the reference memory and error counter.
  task automatic xfer(input logic ins,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input string tag);
    logic [31:0] exp_d;
    logic [31:0] rd;
    bit          oor;
    int          lat;
    int          w;
    oor = (a >= 32'h1000);
    w = int'(a[11:2]);
    exp_d = '0;
    if (!oor) begin
      if (s != 0 && !ins) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        exp_d = model_mem[w];
      end
    end
    if ((oor || (ins && s != 0)) && model_err < 255) model_err++;

    @(negedge clk);
    bus.ext_valid = 1'b1;
    bus.ext_instruction = ins;
    bus.ext_address = a;
    bus.ext_write_data = d;
    bus.ext_write_strobe = s;
    @(posedge clk);
    #1;
    bus.ext_valid = 1'b0;
    bus.ext_instruction = 1'($urandom);
    bus.ext_address = $urandom;
    bus.ext_write_data = $urandom;
    bus.ext_write_strobe = 4'($urandom);
    check({tag, ":busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ext_ready) break;
    end
    rd = bus.ext_read_data;
    check({tag, ":lat"}, lat, 3);
    check({tag, ":data"}, rd, exp_d);
    check({tag, ":err"}, 32'(err_count), model_err);
    @(posedge clk);
    #1;
    check({tag, ":pulse"}, 32'(bus.ext_ready), 32'd0);
    check({tag, ":hold"}, bus.ext_read_data, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ins;
    int          hits;

    bus.ext_valid = 1'b0;
    bus.ext_instruction = 1'b0;
    bus.ext_address = '0;
    bus.ext_write_data = '0;
    bus.ext_write_strobe = '0;
    bus0.ext_valid = 1'b1;
    bus0.ext_instruction = 1'b0;
    bus0.ext_address = '0;
    bus0.ext_write_data = '0;
    bus0.ext_write_strobe = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst:ready", 32'(bus.ext_ready), 32'd0);
    check("rst:data", bus.ext_read_data, 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:err", 32'(err_count), 32'd0);
    check("rst0:ready", 32'(bus0.ext_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait instance with valid held: ready on every 2nd edge
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("w0:ready%0d", k), 32'(bus0.ext_ready),
            32'((k % 2) == 0));
    end
    bus0.ext_valid = 1'b0;

    xfer(1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, "wr10");
    xfer(1'b0, 32'h10, 32'h0, 4'b0000, "rd10");

    xfer(1'b0, 32'h20, 32'h11223344, 4'b1111, "wr20");
    xfer(1'b0, 32'h20, 32'h000000AA, 4'b0001, "wr20b");
    xfer(1'b0, 32'h20, 32'h0, 4'b0000, "rd20");

    xfer(1'b0, 32'h40, 32'hCAFEF00D, 4'b1111, "wr40");
    xfer(1'b1, 32'h40, 32'h12345678, 4'b1111, "fetch40");
    xfer(1'b0, 32'h40, 32'h0, 4'b0000, "rd40");

    // Reset while the write to 0x30 is still waiting
    xfer(1'b0, 32'h30, 32'h55AA55AA, 4'b1111, "wr30");
    @(negedge clk);
    bus.ext_valid = 1'b1;
    bus.ext_address = 32'h30;
    bus.ext_write_data = 32'hFFFFFFFF;
    bus.ext_write_strobe = 4'b1111;
    bus.ext_instruction = 1'b0;
    @(posedge clk);
    #1;
    bus.ext_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_err = 0;
    check("abort:ready", 32'(bus.ext_ready), 32'd0);
    check("abort:data", bus.ext_read_data, 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.ext_ready) hits++;
    end
    check("abort:nopulse", hits, 0);
    xfer(1'b0, 32'h30, 32'h0, 4'b0000, "rd30");

    for (int i = 0; i < 300; i++) begin
      xfer(1'b0, 32'h1000, 32'h0, 4'b0000, $sformatf("oor%0d", i));
    end
    check("oor:sat", 32'(err_count), 32'd255);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 32'h100 + 32'(i * 4), $urandom, 4'b1111,
           $sformatf("init%0d", i));
    end
    for (int i = 0; i < 60; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + ($urandom & 32'hFFFC);
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      ins = ($urandom_range(0, 9) == 0);
      xfer(ins, a, d, s, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, added wait states per transfer (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ext_valid  input  1  initiator requests a transfer.
REQ-006 SHALL have port ext_instruction  input  1  request is an instruction fetch.
REQ-007 SHALL have port ext_address  input  32  byte address, word-aligned by initiator; bits [1:0] ignored.
REQ-008 SHALL have port ext_write_data  input  32  lane-aligned store data.
REQ-009 SHALL have port ext_write_strobe  input  4  byte-lane enables; 0000 means read.
REQ-010 SHALL have port ext_ready  output  1  one-cycle transfer-complete pulse.
REQ-011 SHALL have port ext_read_data  output  32  response data, registered.
REQ-012 SHALL have port busy  output  1  high in WAIT and RESP states.
REQ-013 SHALL have port err_count  output  8  saturating count of erroneous requests.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP.
REQ-015 IDLE with ext_valid=1 SHALL capture address, write data, strobe and instruction flag, then go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT SHALL count down captured WAIT_CYCLES; on final count go to RESP.
REQ-017 RESP SHALL assert ext_ready for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Request-to-ready latency SHALL be WAIT_CYCLES+1 cycles from the capture edge; minimum spacing between ready pulses WAIT_CYCLES+2 cycles.
REQ-019 Input changes after capture SHALL be ignored until the next IDLE.
REQ-020 Word index SHALL be ext_address[log2(DEPTH)+1:2]; address >= DEPTH*4 is out-of-range.
REQ-021 In-range read: ext_read_data SHALL equal memory word, valid in the ready cycle and held until the next response.
REQ-022 In-range write: each lane with strobe bit set SHALL be updated on the RESP edge; other lanes unchanged; ext_read_data SHALL be 0 for that response.
REQ-023 Write followed by read of same word SHALL return the written bytes.
REQ-024 Out-of-range access SHALL complete normally (ready pulsed), return 0, drop any write, increment err_count.
REQ-025 ext_instruction=1 with nonzero strobe SHALL be treated as a read and SHALL increment err_count.
REQ-026 err_count SHALL saturate at 255; one increment per erroneous transfer, applied in RESP.
REQ-027 ext_valid=0 in IDLE SHALL leave state, outputs and memory unchanged.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, ext_ready=0, ext_read_data=0, busy=0, err_count=0, wait counter=0.
REQ-029 Reset during WAIT or RESP SHALL abort the transfer without ready pulse or memory write.
REQ-030 Memory contents SHALL NOT be reset.

Structure
REQ-031 State encoding, WAIT_CYCLES width (4 bits) and strobe width SHALL live in shared package busio_pkg.
REQ-032 Byte-enable word storage SHALL be sub-module bus_word_ram (parameter DEPTH, 4 lane write enables, synchronous read/write).

Verification
REQ-033 Write 0xDEADBEEF strobe 1111 to 0x10, then read 0x10 -> ready 3 cycles after each capture (WAIT_CYCLES=2), read data 0xDEADBEEF.
REQ-034 Write 0x000000AA strobe 0001 over 0x11223344 at 0x20, read -> 0x112233AA.
REQ-035 Read 0x0000_1000 with DEPTH=1024 -> data 0, err_count 1; repeat 300 times -> err_count 255.
REQ-036 Fetch (ext_instruction=1) with strobe 1111 to 0x40 -> word unchanged, err_count +1, ready pulsed.
REQ-037 rst_n=0 during WAIT of a write to 0x30 -> no ready pulse, 0x30 holds prior value, outputs 0.
REQ-038 WAIT_CYCLES=0, ext_valid held 1 -> ready every 2nd cycle, never two consecutive cycles.
